// File: rtl/channel_start_scheduler_pkg.sv
// rtl/channel_start_scheduler_pkg.sv - shared types and constants for the channel start scheduler
//
// Purpose: scheduler FSM state encoding, default channel count, and the
//          command opcode the decoder uses when it drives the cfg_* port.
// Ports:   none (package).

package channel_start_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_OUTPUT_NUM = 16;

  // Decoder opcode that maps onto a cfg_we_i/cfg_sel_i/cfg_en_i/cfg_delay_i write.
  localparam logic [7:0] CMD_SCHED = 8'h5C;

endpackage

// File: rtl/channel_start_scheduler.sv
// rtl/channel_start_scheduler.sv - per-channel delayed start sequencer with batch done reporting
//
// Purpose: holds a per-channel enable bit and start delay. One trigger starts
//          a batch: every enabled channel receives a one-cycle start tick when
//          the batch counter equals its delay. Done ticks from fired channels
//          are collected, and one done tick is reported for the whole batch.
//          Abort stops the batch and pulses stop_o to every enabled channel.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   cfg_we_i         config write strobe (accepted only when idle and in range)
//   cfg_sel_i        channel index for the write
//   cfg_en_i         enable bit written to the selected channel
//   cfg_delay_i      start delay written to the selected channel
//   trigger_i        start-batch pulse (ignored unless idle)
//   abort_i          abort a running batch
//   ch_done_i        done ticks from the channels
//   start_tick_o     one-cycle start pulse per channel
//   stop_o           one-cycle stop pulse per channel on abort
//   busy_o           batch in progress (S_RUN or S_WAIT)
//   done_tick_o      one-cycle batch-complete pulse
//   cfg_err_tick_o   one-cycle pulse after a rejected config write

module channel_start_scheduler
  import channel_start_scheduler_pkg::*;
#(
  parameter int OUTPUT_NUM = DEFAULT_OUTPUT_NUM,
  parameter int SEL_BIT    = 4,
  parameter int DELAY_BIT  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [SEL_BIT-1:0]    cfg_sel_i,
  input  logic                  cfg_en_i,
  input  logic [DELAY_BIT-1:0]  cfg_delay_i,
  input  logic                  trigger_i,
  input  logic                  abort_i,
  input  logic [OUTPUT_NUM-1:0] ch_done_i,
  output logic [OUTPUT_NUM-1:0] start_tick_o,
  output logic [OUTPUT_NUM-1:0] stop_o,
  output logic                  busy_o,
  output logic                  done_tick_o,
  output logic                  cfg_err_tick_o
);

  state_e                state_q, state_d;
  logic [OUTPUT_NUM-1:0] en_q, en_d;
  logic [OUTPUT_NUM-1:0] fired_q, fired_d;
  logic [OUTPUT_NUM-1:0] done_mask_q, done_mask_d;
  logic [DELAY_BIT-1:0]  delay_q [OUTPUT_NUM];
  logic [DELAY_BIT-1:0]  delay_d [OUTPUT_NUM];
  logic [DELAY_BIT-1:0]  count_q, count_d;
  logic                  done_tick_q, done_tick_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [OUTPUT_NUM-1:0] hit;
  logic [OUTPUT_NUM-1:0] start_tick;
  logic [OUTPUT_NUM-1:0] fired_now;
  logic [OUTPUT_NUM-1:0] done_now;
  logic [31:0]           sel_ext;
  logic                  running;
  logic                  aborting;
  logic                  cfg_ok;

  assign sel_ext  = 32'(cfg_sel_i);
  assign running  = (state_q == S_RUN) || (state_q == S_WAIT);
  assign aborting = running && abort_i;
  assign cfg_ok   = (state_q == S_IDLE) && (sel_ext < 32'(OUTPUT_NUM));

  // Per-channel start compare against the shared batch counter.
  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_cmp
    assign hit[k] = en_q[k] && (count_q == delay_q[k]);
  end

  // Abort suppresses any tick that would otherwise land in the same cycle.
  assign start_tick = (state_q == S_RUN && !abort_i) ? hit : '0;
  assign fired_now  = fired_q | start_tick;
  // Only channels that fired in an earlier cycle may contribute a done tick.
  assign done_now   = done_mask_q | (ch_done_i & fired_q);

  assign start_tick_o   = start_tick;
  assign stop_o         = aborting ? en_q : '0;
  assign busy_o         = running;
  assign done_tick_o    = done_tick_q;
  assign cfg_err_tick_o = cfg_err_q;

  // Channel table update.
  always_comb begin
    for (int k = 0; k < OUTPUT_NUM; k++) begin
      delay_d[k] = delay_q[k];
      en_d[k]    = en_q[k];
      if (cfg_we_i && cfg_ok && (sel_ext == 32'(k))) begin
        delay_d[k] = cfg_delay_i;
        en_d[k]    = cfg_en_i;
      end
    end
  end

  // Batch FSM next state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fired_d     = fired_q;
    done_mask_d = done_mask_q;
    done_tick_d = (state_q == S_DONE);
    cfg_err_d   = cfg_we_i && !cfg_ok;

    case (state_q)
      S_IDLE: begin
        if (trigger_i) begin
          if (en_q != '0) begin
            state_d     = S_RUN;
            count_d     = '0;
            fired_d     = '0;
            done_mask_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        count_d     = count_q + 1'b1;
        fired_d     = fired_now;
        done_mask_d = done_now;
        if (fired_now == en_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        done_mask_d = done_now;
        if (done_now == en_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (aborting) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      fired_q     <= '0;
      done_mask_q <= '0;
      count_q     <= '0;
      done_tick_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int k = 0; k < OUTPUT_NUM; k++) delay_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      fired_q     <= fired_d;
      done_mask_q <= done_mask_d;
      count_q     <= count_d;
      done_tick_q <= done_tick_d;
      cfg_err_q   <= cfg_err_d;
      delay_q     <= delay_d;
    end
  end

endmodule

// File: tb/tb_channel_start_scheduler.sv
// tb/tb_channel_start_scheduler.sv - directed self-checking bench for channel_start_scheduler

module tb_channel_start_scheduler;

  localparam int N  = 16;
  localparam int SB = 5;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_we_i;
  logic [SB-1:0] cfg_sel_i;
  logic          cfg_en_i;
  logic [DB-1:0] cfg_delay_i;
  logic          trigger_i;
  logic          abort_i;
  logic [N-1:0]  ch_done_i;
  logic [N-1:0]  start_tick_o;
  logic [N-1:0]  stop_o;
  logic          busy_o;
  logic          done_tick_o;
  logic          cfg_err_tick_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  channel_start_scheduler #(
    .OUTPUT_NUM (N),
    .SEL_BIT    (SB),
    .DELAY_BIT  (DB)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_delay_i    (cfg_delay_i),
    .trigger_i      (trigger_i),
    .abort_i        (abort_i),
    .ch_done_i      (ch_done_i),
    .start_tick_o   (start_tick_o),
    .stop_o         (stop_o),
    .busy_o         (busy_o),
    .done_tick_o    (done_tick_o),
    .cfg_err_tick_o (cfg_err_tick_o)
  );

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic write_cfg(input int sel, input logic en, input int dly);
    cfg_we_i    = 1'b1;
    cfg_sel_i   = SB'(sel);
    cfg_en_i    = en;
    cfg_delay_i = DB'(dly);
    cycle();
    cfg_we_i    = 1'b0;
  endtask

  task automatic fire();
    trigger_i = 1'b1;
    cycle();
    trigger_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_sel_i = '0; cfg_en_i = 1'b0; cfg_delay_i = '0;
    trigger_i = 1'b0; abort_i = 1'b0; ch_done_i = '0;
    cycle(); cycle();
    n_cmp++; if (start_tick_o !== 16'h0000) begin n_err++; $display("FAIL reset_start got %h want 0000", start_tick_o); end
    n_cmp++; if (stop_o !== 16'h0000) begin n_err++; $display("FAIL reset_stop got %h want 0000", stop_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_tick_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_tick_o); end
    n_cmp++; if (cfg_err_tick_o !== 1'b0) begin n_err++; $display("FAIL reset_cfgerr got %b want 0", cfg_err_tick_o); end
    rst_i = 1'b0;
    cycle();
  endtask

  // ch0/ch3/ch15 with delays 0/5/2; each reports done 10 cycles after its tick.
  task automatic test_staggered();
    logic [N-1:0] exp_tick;
    write_cfg(0, 1'b1, 0);
    write_cfg(3, 1'b1, 5);
    write_cfg(15, 1'b1, 2);
    fire();
    for (int c = 1; c <= 20; c++) begin
      ch_done_i = (c == 11) ? 16'h0001 : (c == 13) ? 16'h8000 : (c == 16) ? 16'h0008 : 16'h0000;
      #1;
      exp_tick = (c == 1) ? 16'h0001 : (c == 3) ? 16'h8000 : (c == 6) ? 16'h0008 : 16'h0000;
      n_cmp++; if (start_tick_o !== exp_tick) begin n_err++; $display("FAIL stag_tick c=%0d got %h want %h", c, start_tick_o, exp_tick); end
      n_cmp++; if (busy_o !== (c <= 16)) begin n_err++; $display("FAIL stag_busy c=%0d got %b want %b", c, busy_o, (c <= 16)); end
      n_cmp++; if (done_tick_o !== (c == 18)) begin n_err++; $display("FAIL stag_done c=%0d got %b want %b", c, done_tick_o, (c == 18)); end
      cycle();
    end
    ch_done_i = '0;
  endtask

  // ch1/ch2 share delay 4; an early done on unfired channels is ignored.
  task automatic test_equal_delay();
    logic [N-1:0] exp_tick;
    write_cfg(0, 1'b0, 0);
    write_cfg(3, 1'b0, 0);
    write_cfg(15, 1'b0, 0);
    write_cfg(1, 1'b1, 4);
    write_cfg(2, 1'b1, 4);
    fire();
    for (int c = 1; c <= 12; c++) begin
      ch_done_i = (c == 3) ? 16'h0006 : (c == 7) ? 16'h0004 : (c == 9) ? 16'h0002 : 16'h0000;
      #1;
      exp_tick = (c == 5) ? 16'h0006 : 16'h0000;
      n_cmp++; if (start_tick_o !== exp_tick) begin n_err++; $display("FAIL eq_tick c=%0d got %h want %h", c, start_tick_o, exp_tick); end
      n_cmp++; if (busy_o !== (c <= 9)) begin n_err++; $display("FAIL eq_busy c=%0d got %b want %b", c, busy_o, (c <= 9)); end
      n_cmp++; if (done_tick_o !== (c == 11)) begin n_err++; $display("FAIL eq_done c=%0d got %b want %b", c, done_tick_o, (c == 11)); end
      cycle();
    end
    ch_done_i = '0;
  endtask

  task automatic test_empty_batch();
    write_cfg(1, 1'b0, 0);
    write_cfg(2, 1'b0, 0);
    fire();
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_cmp++; if (start_tick_o !== 16'h0000) begin n_err++; $display("FAIL empty_tick c=%0d got %h want 0000", c, start_tick_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL empty_busy c=%0d got %b want 0", c, busy_o); end
      n_cmp++; if (done_tick_o !== (c == 2)) begin n_err++; $display("FAIL empty_done c=%0d got %b want %b", c, done_tick_o, (c == 2)); end
      cycle();
    end
  endtask

  task automatic test_cfg_reject();
    write_cfg(4, 1'b1, 3);
    n_cmp++; if (cfg_err_tick_o !== 1'b0) begin n_err++; $display("FAIL rej_goodwrite got %b want 0", cfg_err_tick_o); end
    write_cfg(16, 1'b1, 0);
    n_cmp++; if (cfg_err_tick_o !== 1'b1) begin n_err++; $display("FAIL rej_range got %b want 1", cfg_err_tick_o); end
    cycle();
    n_cmp++; if (cfg_err_tick_o !== 1'b0) begin n_err++; $display("FAIL rej_range_pulse got %b want 0", cfg_err_tick_o); end
    fire();
    for (int c = 1; c <= 8; c++) begin
      cfg_we_i = (c == 1); cfg_sel_i = 5'd4; cfg_en_i = 1'b0; cfg_delay_i = '0;
      ch_done_i = (c == 5) ? 16'h0010 : 16'h0000;
      #1;
      n_cmp++; if (start_tick_o !== ((c == 4) ? 16'h0010 : 16'h0000)) begin n_err++; $display("FAIL rej_tick c=%0d got %h want %h", c, start_tick_o, ((c == 4) ? 16'h0010 : 16'h0000)); end
      n_cmp++; if (cfg_err_tick_o !== (c == 2)) begin n_err++; $display("FAIL rej_busy_err c=%0d got %b want %b", c, cfg_err_tick_o, (c == 2)); end
      n_cmp++; if (done_tick_o !== (c == 7)) begin n_err++; $display("FAIL rej_done c=%0d got %b want %b", c, done_tick_o, (c == 7)); end
      cycle();
    end
    cfg_we_i = 1'b0; ch_done_i = '0;
  endtask

  task automatic test_abort();
    int ticks;
    int dones;
    write_cfg(4, 1'b0, 0);
    write_cfg(0, 1'b1, 0);
    write_cfg(7, 1'b1, 100);
    fire();
    #1;
    n_cmp++; if (start_tick_o !== 16'h0001) begin n_err++; $display("FAIL ab_first_tick got %h want 0001", start_tick_o); end
    cycle();
    abort_i = 1'b1;
    #1;
    n_cmp++; if (stop_o !== 16'h0081) begin n_err++; $display("FAIL ab_stop got %h want 0081", stop_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL ab_busy_before got %b want 1", busy_o); end
    cycle();
    abort_i = 1'b0;
    #1;
    n_cmp++; if (stop_o !== 16'h0000) begin n_err++; $display("FAIL ab_stop_pulse got %h want 0000", stop_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ab_busy_after got %b want 0", busy_o); end
    ticks = 0; dones = 0;
    for (int c = 0; c < 110; c++) begin
      if (start_tick_o != '0) ticks++;
      if (done_tick_o) dones++;
      cycle();
    end
    n_cmp++; if (ticks !== 0) begin n_err++; $display("FAIL ab_no_ticks got %0d want 0", ticks); end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL ab_no_done got %0d want 0", dones); end
    abort_i = 1'b1;
    #1;
    n_cmp++; if (stop_o !== 16'h0000) begin n_err++; $display("FAIL ab_idle_stop got %h want 0000", stop_o); end
    cycle();
    abort_i = 1'b0;
    fire();
    abort_i = 1'b1;
    #1;
    n_cmp++; if (start_tick_o !== 16'h0000) begin n_err++; $display("FAIL ab_tick_masked got %h want 0000", start_tick_o); end
    n_cmp++; if (stop_o !== 16'h0081) begin n_err++; $display("FAIL ab_retained_stop got %h want 0081", stop_o); end
    cycle();
    abort_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ab2_busy got %b want 0", busy_o); end
    cycle();
    n_cmp++; if (done_tick_o !== 1'b0) begin n_err++; $display("FAIL ab2_done got %b want 0", done_tick_o); end
  endtask

  task automatic test_reset_mid_batch();
    write_cfg(7, 1'b1, 1);
    fire();
    #1;
    n_cmp++; if (start_tick_o !== 16'h0001) begin n_err++; $display("FAIL rm_tick0 got %h want 0001", start_tick_o); end
    cycle();
    n_cmp++; if (start_tick_o !== 16'h0080) begin n_err++; $display("FAIL rm_tick7 got %h want 0080", start_tick_o); end
    cycle();
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rm_wait_busy got %b want 1", busy_o); end
    rst_i = 1'b1; ch_done_i = 16'h0081;
    cycle();
    rst_i = 1'b0; ch_done_i = '0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy_o); end
    n_cmp++; if (start_tick_o !== 16'h0000) begin n_err++; $display("FAIL rm_start got %h want 0000", start_tick_o); end
    n_cmp++; if (stop_o !== 16'h0000) begin n_err++; $display("FAIL rm_stop got %h want 0000", stop_o); end
    n_cmp++; if (done_tick_o !== 1'b0) begin n_err++; $display("FAIL rm_done got %b want 0", done_tick_o); end
    cycle();
    n_cmp++; if (done_tick_o !== 1'b0) begin n_err++; $display("FAIL rm_done_late got %b want 0", done_tick_o); end
    fire();
    #1;
    n_cmp++; if (start_tick_o !== 16'h0000) begin n_err++; $display("FAIL rm_retrig_tick got %h want 0000", start_tick_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rm_retrig_busy got %b want 0", busy_o); end
    cycle();
    n_cmp++; if (done_tick_o !== 1'b1) begin n_err++; $display("FAIL rm_retrig_done got %b want 1", done_tick_o); end
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_equal_delay();
    test_empty_batch();
    test_cfg_reject();
    test_abort();
    test_reset_mid_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
